avalon_ram_slave: RTL and testbench



---
 rtl/avalon_pkg.sv | 28 ++
 rtl/avalon_ram_slave_if.sv | 20 ++
 rtl/avalon_wait_gen.sv | 56 +++++
 rtl/avalon_ram_slave.sv | 125 ++++++++++++
 tb/tb_avalon_ram_slave.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_pkg.sv
// rtl/avalon_pkg.sv - shared types, constants and helpers for the Avalon-MM RAM slave
package avalon_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [7:0]  LFSR_SEED         = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1 expressed as the bits XORed into the shift-in position
    localparam logic [7:0]  LFSR_TAPS         = 8'hB8;
    localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/avalon_ram_slave_if.sv
// rtl/avalon_ram_slave_if.sv - Avalon-MM master/slave bus bundle
interface avalon_ram_slave_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_wait_gen.sv
// rtl/avalon_wait_gen.sv - latency source (fixed or LFSR) and stall countdown
module avalon_wait_gen
    import avalon_pkg::*;
#(
    parameter int unsigned READ_WAIT   = 0,
    parameter int unsigned WRITE_WAIT  = 0,
    parameter int unsigned RANDOM_WAIT = 0,
    parameter int unsigned MAX_WAIT    = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic step,
    input  logic is_write,
    output logic busy,
    output logic done
);

    localparam logic [4:0] WAIT_MOD = 5'(MAX_WAIT + 1);

    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] lat;

    always_comb begin
        if (RANDOM_WAIT != 0) begin
            lat = 4'({1'b0, lfsr_q[3:0]} % WAIT_MOD);
        end else begin
            lat = is_write ? 4'(WRITE_WAIT) : 4'(READ_WAIT);
        end

        lfsr_d = start ? lfsr_next(lfsr_q) : lfsr_q;

        // First stall cycle is the start cycle itself, so load L-1
        cnt_d = cnt_q;
        if (start && lat != 4'd0) begin
            cnt_d = lat - 4'd1;
        end else if (step && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
            cnt_q  <= 4'd0;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy = (lat != 4'd0);
    assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/avalon_ram_slave.sv
// rtl/avalon_ram_slave.sv - word RAM behind an Avalon-MM slave with programmable wait states
module avalon_ram_slave
    import avalon_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR     = MIPS_RESET_VECTOR,
    parameter int unsigned READ_WAIT     = 0,
    parameter int unsigned WRITE_WAIT    = 0,
    parameter int unsigned RANDOM_WAIT   = 0,
    parameter int unsigned MAX_WAIT      = 7,
    parameter string       RAM_INIT_FILE = ""
) (
    input  logic               clk,
    input  logic               reset,
    avalon_ram_slave_if.slave  bus,
    output logic               err
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] END_ADDR = 64'(BASE_ADDR) + 64'(DEPTH_WORDS) * 64'd4;

    logic [31:0] mem_q [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic        err_q, err_d;
    logic        wait_prev_q, wait_prev_d;
    logic [65:0] snap_q, snap_d;

    logic        req, both, addr_ok, changed;
    logic [31:0] offset;
    logic [IDX_W-1:0] idx;
    logic        lat_busy, cnt_done;
    logic        wait_req, complete, mem_we;
    logic [31:0] mem_wdata;

    assign req     = bus.read | bus.write;
    assign both    = bus.read & bus.write;
    assign offset  = bus.address - BASE_ADDR;
    assign idx     = IDX_W'(offset >> 2);
    assign addr_ok = (bus.address[1:0] == 2'b00) && (bus.address >= BASE_ADDR)
                  && (64'(bus.address) < END_ADDR);

    avalon_wait_gen #(
        .READ_WAIT   (READ_WAIT),
        .WRITE_WAIT  (WRITE_WAIT),
        .RANDOM_WAIT (RANDOM_WAIT),
        .MAX_WAIT    (MAX_WAIT)
    ) u_wait_gen (
        .clk      (clk),
        .reset    (reset),
        .start    (state_q == IDLE && req),
        .step     (state_q == BUSY && req),
        .is_write (bus.write),
        .busy     (lat_busy),
        .done     (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        wait_req = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (lat_busy) begin
                        wait_req = 1'b1;
                        state_d  = BUSY;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (!cnt_done) begin
                    wait_req = 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A master must hold its request stable while stalled; dropping it entirely is an abort
    always_comb begin
        snap_d      = {bus.address, bus.read, bus.write, bus.writedata};
        wait_prev_d = wait_req;
        changed     = wait_prev_q & req & (snap_d != snap_q);
        err_d       = err_q | (req & (both | ~addr_ok)) | changed;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            wait_prev_q <= 1'b0;
            snap_q      <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            wait_prev_q <= wait_prev_d;
            snap_q      <= snap_d;
        end
    end

    always_comb begin
        mem_we    = complete & bus.write & ~bus.read & addr_ok & reset;
        mem_wdata = merge_bytes(mem_q[idx], bus.writedata, bus.byteenable);
    end

    // Storage is deliberately outside the reset domain so contents survive a CPU reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= mem_wdata;
        end
    end

    assign bus.waitrequest = wait_req;
    assign bus.readdata    = (complete & bus.read & ~bus.write & addr_ok) ? mem_q[idx] : 32'h0;
    assign err             = err_q;

endmodule

// File: tb/tb_avalon_ram_slave.sv
// tb/tb_avalon_ram_slave.sv - scoreboard bench for avalon_ram_slave
module tb_avalon_ram_slave;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0][31:0] m_addr, m_wdata;
    logic [2:0]       m_rd, m_wr;
    logic [2:0][3:0]  m_be;
    logic [2:0]       s_wait, s_err;
    logic [2:0][31:0] s_rdata;

    int rw_cfg  [3] = '{0, 3, 0};
    int ww_cfg  [3] = '{2, 3, 0};
    int rnd_cfg [3] = '{0, 0, 1};

    avalon_ram_slave_if bus0 ();
    avalon_ram_slave_if bus1 ();
    avalon_ram_slave_if bus2 ();

    assign bus0.address = m_addr[0];  assign bus0.read = m_rd[0];  assign bus0.write = m_wr[0];
    assign bus0.writedata = m_wdata[0];  assign bus0.byteenable = m_be[0];
    assign s_wait[0] = bus0.waitrequest;  assign s_rdata[0] = bus0.readdata;
    assign bus1.address = m_addr[1];  assign bus1.read = m_rd[1];  assign bus1.write = m_wr[1];
    assign bus1.writedata = m_wdata[1];  assign bus1.byteenable = m_be[1];
    assign s_wait[1] = bus1.waitrequest;  assign s_rdata[1] = bus1.readdata;
    assign bus2.address = m_addr[2];  assign bus2.read = m_rd[2];  assign bus2.write = m_wr[2];
    assign bus2.writedata = m_wdata[2];  assign bus2.byteenable = m_be[2];
    assign s_wait[2] = bus2.waitrequest;  assign s_rdata[2] = bus2.readdata;

    avalon_ram_slave #(.READ_WAIT(0), .WRITE_WAIT(2)) u_dut0 (
        .clk(clk), .reset(rst_n), .bus(bus0), .err(s_err[0]));
    avalon_ram_slave #(.READ_WAIT(3), .WRITE_WAIT(3)) u_dut1 (
        .clk(clk), .reset(rst_n), .bus(bus1), .err(s_err[1]));
    avalon_ram_slave #(.RANDOM_WAIT(1), .MAX_WAIT(7)) u_dut2 (
        .clk(clk), .reset(rst_n), .bus(bus2), .err(s_err[2]));

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          stalls;
    } exp_t;

    exp_t        exp_q [$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] ref_mem [3][256];
    logic [2:0]  ref_err;
    logic [7:0]  ref_lfsr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic take_lat(input int inst, input bit wr, output int l);
        if (rnd_cfg[inst] != 0) begin
            l = int'(ref_lfsr[3:0]) % 8;
            ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
        end else begin
            l = wr ? ww_cfg[inst] : rw_cfg[inst];
        end
    endtask

    task automatic issue(input int inst, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        int          l;
        int          idx;
        bit          ok;
        logic [31:0] exp_d;
        take_lat(inst, wr, l);
        ok  = (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'd1024);
        idx = ok ? int'((a - BASE) >> 2) : 0;
        if ((rd && wr) || !ok) ref_err[inst] = 1'b1;
        exp_d = (rd && !wr && ok) ? ref_mem[inst][idx] : 32'h0;
        if (wr && !rd && ok) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[inst][idx][8*b +: 8] = d[8*b +: 8];
        end
        exp_q.push_back('{inst, exp_d, l});
        m_addr[inst] = a; m_rd[inst] = rd; m_wr[inst] = wr; m_wdata[inst] = d; m_be[inst] = be;
    endtask

    task automatic wait_done(input int inst);
        bit w;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            w = s_wait[inst];
            @(posedge clk);
            #1;
            if (!w) return;
        end
        n_total++;
        $display("FAIL timeout inst %0d: waitrequest still 1 after 40 cycles, required 0", inst);
    endtask

    task automatic req(input int inst, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        issue(inst, rd, wr, a, d, be);
        wait_done(inst);
    endtask

    task automatic idle(input int inst);
        m_rd[inst] = 1'b0;
        m_wr[inst] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ref_lfsr = 8'hA5;
        ref_err  = '0;
    endtask

    // Monitor: counts stall cycles per instance and scores each completion
    initial begin
        int   st [3];
        exp_t e;
        for (int i = 0; i < 3; i++) st[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!(m_rd[i] | m_wr[i])) begin
                    st[i] = 0;
                    chk("idle_wait", 32'(s_wait[i]), 32'h0);
                    chk("idle_rdata", s_rdata[i], 32'h0);
                end else if (s_wait[i]) begin
                    st[i]++;
                    chk("stall_rdata", s_rdata[i], 32'h0);
                end else begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_completion inst %0d: got completion, required none", i);
                    end else begin
                        e = exp_q.pop_front();
                        chk("compl_inst", 32'(i), 32'(e.inst));
                        chk("stall_count", 32'(st[i]), 32'(e.stalls));
                        chk("readdata", s_rdata[i], e.data);
                        if (rnd_cfg[i] != 0) chk("stall_bound", 32'(st[i] <= 7), 32'h1);
                    end
                    st[i] = 0;
                end
            end
        end
    end

    initial begin
        int l;
        m_addr = '0; m_wdata = '0; m_rd = '0; m_wr = '0; m_be = '0;
        ref_lfsr = 8'hA5;
        ref_err  = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_wait", 32'(s_wait[i]), 32'h0);
            chk("reset_rdata", s_rdata[i], 32'h0);
            chk("reset_err", 32'(s_err[i]), 32'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // zero-latency read, byte-lane merge, empty byteenable
        req(0, 0, 1, BASE, 32'h3C021234, 4'hF);
        req(0, 1, 0, BASE, 32'h0, 4'h0);
        chk("t1_err", 32'(s_err[0]), 32'(ref_err[0]));
        req(0, 0, 1, BASE + 32'd4, 32'h11223344, 4'hF);
        req(0, 0, 1, BASE + 32'd4, 32'hDEADBEEF, 4'b0101);
        req(0, 1, 0, BASE + 32'd4, 32'h0, 4'h0);
        req(0, 0, 1, BASE + 32'd4, 32'h0, 4'h0);
        req(0, 1, 0, BASE + 32'd4, 32'h0, 4'h0);
        idle(0);

        // abort after one stall, then a full-latency read
        req(1, 0, 1, BASE + 32'd8, 32'hCAFEF00D, 4'hF);
        req(1, 0, 1, BASE + 32'd12, 32'h0BADC0DE, 4'hF);
        idle(1);
        take_lat(1, 1'b0, l);
        m_addr[1] = BASE + 32'd8; m_rd[1] = 1'b1;
        @(posedge clk);
        #1;
        idle(1);
        chk("t3_abort_err", 32'(s_err[1]), 32'(ref_err[1]));
        req(1, 1, 0, BASE + 32'd8, 32'h0, 4'h0);
        idle(1);

        // address moved while stalled: completion uses the new address and flags an error
        take_lat(1, 1'b0, l);
        exp_q.push_back('{1, ref_mem[1][3], l});
        m_addr[1] = BASE + 32'd8; m_rd[1] = 1'b1;
        @(posedge clk);
        #1;
        m_addr[1] = BASE + 32'd12;
        ref_err[1] = 1'b1;
        wait_done(1);
        idle(1);
        chk("proto_err", 32'(s_err[1]), 32'(ref_err[1]));

        // out-of-range, misaligned and last-word boundaries
        req(0, 1, 0, 32'h0, 32'h0, 4'h0);
        req(0, 0, 1, BASE + 32'd2, 32'hFFFFFFFF, 4'hF);
        req(0, 1, 0, BASE, 32'h0, 4'h0);
        req(0, 0, 1, BASE + 32'd1020, 32'h5A5A0FF0, 4'hF);
        req(0, 1, 0, BASE + 32'd1020, 32'h0, 4'h0);
        req(0, 1, 0, BASE + 32'd1024, 32'h0, 4'h0);
        req(0, 1, 1, BASE, 32'h0, 4'hF);
        idle(0);
        chk("t4_err_sticky", 32'(s_err[0]), 32'(ref_err[0]));
        repeat (3) @(posedge clk);
        #1;
        chk("t4_err_held", 32'(s_err[0]), 32'(ref_err[0]));
        do_reset();
        chk("t4_err_cleared0", 32'(s_err[0]), 32'(ref_err[0]));
        chk("t4_err_cleared1", 32'(s_err[1]), 32'(ref_err[1]));

        // reset in the middle of a stalled write
        req(1, 0, 1, BASE + 32'd16, 32'h01020304, 4'hF);
        req(1, 0, 1, BASE + 32'd20, 32'hA1B2C3D4, 4'hF);
        idle(1);
        m_addr[1] = BASE + 32'd16; m_wdata[1] = 32'h12345678; m_be[1] = 4'hF; m_wr[1] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        m_wr[1] = 1'b0;
        #1;
        chk("t6_wait", 32'(s_wait[1]), 32'h0);
        chk("t6_err", 32'(s_err[1]), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ref_lfsr = 8'hA5;
        ref_err  = '0;
        req(1, 1, 0, BASE + 32'd16, 32'h0, 4'h0);
        req(1, 1, 0, BASE + 32'd20, 32'h0, 4'h0);
        req(1, 1, 0, BASE + 32'd8, 32'h0, 4'h0);
        idle(1);

        // pseudo-random latency, back-to-back traffic
        for (int i = 0; i < 16; i++)
            req(2, 0, 1, BASE + 32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 16; i++)
            req(2, 0, 1, BASE + 32'(4 * $urandom_range(0, 15)), $urandom, 4'($urandom));
        for (int i = 0; i < 16; i++)
            req(2, 1, 0, BASE + 32'(4 * $urandom_range(0, 15)), 32'h0, 4'h0);
        idle(2);
        chk("t5_err", 32'(s_err[2]), 32'(ref_err[2]));
        chk("queue_empty", 32'(exp_q.size()), 32'h0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
